// File: rtl/alu_result_sink_pkg.sv
// Shared ALU definitions: flag indices, condition codes, op codes.
// Imported by the result sink and its skid buffer.
package alu_result_sink_pkg;

  localparam int ZeroFlag  = 0;
  localparam int CarryFlag = 1;
  localparam int NegFlag   = 2;
  localparam int OverFlag  = 3;

  localparam logic [3:0] Cond_AL = 4'd0;
  localparam logic [3:0] Cond_EQ = 4'd1;
  localparam logic [3:0] Cond_NE = 4'd2;
  localparam logic [3:0] Cond_CS = 4'd3;
  localparam logic [3:0] Cond_CC = 4'd4;
  localparam logic [3:0] Cond_MI = 4'd5;
  localparam logic [3:0] Cond_PL = 4'd6;
  localparam logic [3:0] Cond_VS = 4'd7;
  localparam logic [3:0] Cond_VC = 4'd8;
  localparam logic [3:0] Cond_HI = 4'd9;
  localparam logic [3:0] Cond_LS = 4'd10;
  localparam logic [3:0] Cond_GE = 4'd11;
  localparam logic [3:0] Cond_LT = 4'd12;
  localparam logic [3:0] Cond_GT = 4'd13;
  localparam logic [3:0] Cond_LE = 4'd14;
  localparam logic [3:0] Cond_NV = 4'd15;

  typedef enum logic [3:0] {
    FuncAdd  = 4'd0,
    FuncAdc  = 4'd1,
    FuncSub  = 4'd2,
    FuncSbc  = 4'd3,
    FuncAnd  = 4'd4,
    FuncOr   = 4'd5,
    FuncXor  = 4'd6,
    FuncNot  = 4'd7,
    FuncShl  = 4'd8,
    FuncShr  = 4'd9,
    FuncPass = 4'd10
  } func_op_e;

  typedef enum logic [1:0] {
    CntEmpty = 2'd0,
    CntOne   = 2'd1,
    CntFull  = 2'd2
  } cnt_e;

endpackage

// File: rtl/alu_result_sink_if.sv
// ALU result/flag handshake bundle between the ALU and the sink.
// The ALU side is master, the sink is slave.
interface alu_result_sink_if #(
  parameter int DataWidth = 8,
  parameter int FlagBits  = 4,
  parameter int DestBits  = 3
);
  logic [DataWidth-1:0] Y;
  logic [FlagBits-1:0]  OFlags;
  logic [FlagBits-1:0]  FlagMask;
  logic [DestBits-1:0]  InDest;
  logic                 InValid;
  logic                 InReady;

  modport master (
    output Y, OFlags, FlagMask, InDest, InValid,
    input  InReady
  );

  modport slave (
    input  Y, OFlags, FlagMask, InDest, InValid,
    output InReady
  );
endinterface

// File: rtl/alu_result_sink_skid_buffer_2.sv
// Two-entry valid/ready buffer; head/tail registers plus count.
// Ready is registered from the next count so it never depends on inputs.
module skid_buffer_2
  import alu_result_sink_pkg::*;
#(
  parameter int Width = 11
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [Width-1:0] in_data_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic [Width-1:0] out_data_o,
  output logic             out_valid_o,
  input  logic             out_ready_i
);

  cnt_e             cnt_q, cnt_d;
  logic [Width-1:0] head_q, head_d;
  logic [Width-1:0] tail_q, tail_d;
  logic             rdy_q;
  logic             push, pop;

  assign push        = in_valid_i & rdy_q;
  assign pop         = out_valid_o & out_ready_i;
  assign in_ready_o  = rdy_q;
  assign out_valid_o = (cnt_q != CntEmpty);
  assign out_data_o  = head_q;

  always_comb begin
    cnt_d  = cnt_q;
    head_d = head_q;
    tail_d = tail_q;
    unique case (cnt_q)
      CntEmpty: begin
        if (push) begin
          cnt_d  = CntOne;
          head_d = in_data_i;
        end
      end
      CntOne: begin
        if (push && pop) begin
          head_d = in_data_i;
        end else if (push) begin
          cnt_d  = CntFull;
          tail_d = in_data_i;
        end else if (pop) begin
          cnt_d = CntEmpty;
        end
      end
      CntFull: begin
        if (pop) begin
          cnt_d  = CntOne;
          head_d = tail_q;
        end
      end
      default: cnt_d = CntEmpty;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q  <= CntEmpty;
      head_q <= '0;
      tail_q <= '0;
      rdy_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      head_q <= head_d;
      tail_q <= tail_d;
      rdy_q  <= (cnt_d != CntFull);
    end
  end

endmodule

// File: rtl/alu_result_sink.sv
// ALU result sink: skid-buffered write-back, status flags, cond decode.
// ALU_SINK_FORWARD_EN bypasses the pending flag merge onto Status.
module alu_result_sink
  import alu_result_sink_pkg::*;
#(
  parameter int DataWidth = 8,
  parameter int FlagBits  = 4,
  parameter int DestBits  = 3
) (
  input  logic                 Clk,
  input  logic                 Reset,
  alu_result_sink_if.slave     alu,
  output logic [DataWidth-1:0] OutData,
  output logic [DestBits-1:0]  OutDest,
  output logic                 OutValid,
  input  logic                 OutReady,
  output logic [FlagBits-1:0]  Status,
  input  logic [3:0]           CondSel,
  output logic                 CondTrue
);

  localparam int EntW = DataWidth + DestBits;

  logic [FlagBits-1:0] status_q, status_d;
  logic                push;

  skid_buffer_2 #(
    .Width(EntW)
  ) u_buf (
    .clk_i      (Clk),
    .rst_i      (Reset),
    .in_data_i  ({alu.Y, alu.InDest}),
    .in_valid_i (alu.InValid),
    .in_ready_o (alu.InReady),
    .out_data_o ({OutData, OutDest}),
    .out_valid_o(OutValid),
    .out_ready_i(OutReady)
  );

  assign push = alu.InValid & alu.InReady;

  always_comb begin
    status_d = status_q;
    if (push) begin
      status_d = (status_q & ~alu.FlagMask)
               | (alu.OFlags & alu.FlagMask);
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      status_q <= '0;
    end else begin
      status_q <= status_d;
    end
  end

`ifdef ALU_SINK_FORWARD_EN
  assign Status = status_d;
`else
  assign Status = status_q;
`endif

  logic z, c, n, v;
  assign z = Status[ZeroFlag];
  assign c = Status[CarryFlag];
  assign n = Status[NegFlag];
  assign v = Status[OverFlag];

  always_comb begin
    CondTrue = 1'b0;
    unique case (CondSel)
      Cond_AL: CondTrue = 1'b1;
      Cond_EQ: CondTrue = z;
      Cond_NE: CondTrue = ~z;
      Cond_CS: CondTrue = c;
      Cond_CC: CondTrue = ~c;
      Cond_MI: CondTrue = n;
      Cond_PL: CondTrue = ~n;
      Cond_VS: CondTrue = v;
      Cond_VC: CondTrue = ~v;
      Cond_HI: CondTrue = c & ~z;
      Cond_LS: CondTrue = ~c | z;
      Cond_GE: CondTrue = (n == v);
      Cond_LT: CondTrue = (n != v);
      Cond_GT: CondTrue = ~z & (n == v);
      Cond_LE: CondTrue = z | (n != v);
      Cond_NV: CondTrue = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_alu_result_sink.sv
// Scoreboard bench for alu_result_sink: directed plan then random traffic.
// Expected entries and flags come from a queue/arithmetic reference model.
module tb_alu_result_sink;

  localparam int DW = 8;
  localparam int FB = 4;
  localparam int DB = 3;

  logic          Clk = 1'b0;
  logic          Reset = 1'b1;
  logic [DW-1:0] OutData;
  logic [DB-1:0] OutDest;
  logic          OutValid;
  logic          OutReady = 1'b0;
  logic [FB-1:0] Status;
  logic [3:0]    CondSel = 4'd0;
  logic          CondTrue;

  alu_result_sink_if #(
    .DataWidth(DW), .FlagBits(FB), .DestBits(DB)
  ) alu_if ();

  alu_result_sink #(
    .DataWidth(DW), .FlagBits(FB), .DestBits(DB)
  ) dut (
    .Clk     (Clk),
    .Reset   (Reset),
    .alu     (alu_if.slave),
    .OutData (OutData),
    .OutDest (OutDest),
    .OutValid(OutValid),
    .OutReady(OutReady),
    .Status  (Status),
    .CondSel (CondSel),
    .CondTrue(CondTrue)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [DB-1:0] t;
  } ent_t;

  ent_t       exp_q[$];
  logic [3:0] m_status = 4'b0;
  bit         m_rst = 1'b1;
  bit         mon_en = 1'b0;
  bit         pend_acc = 1'b0;
  ent_t       pend_ent;
  logic [3:0] pend_f, pend_m;
  int         n_chk = 0;
  int         n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp,
               $time);
    end
  endtask

  function automatic bit cond(input logic [3:0] s, input logic [3:0] c);
    bit z, cy, n, v;
    z = s[0]; cy = s[1]; n = s[2]; v = s[3];
    case (c)
      4'd0:  return 1'b1;
      4'd1:  return z;
      4'd2:  return !z;
      4'd3:  return cy;
      4'd4:  return !cy;
      4'd5:  return n;
      4'd6:  return !n;
      4'd7:  return v;
      4'd8:  return !v;
      4'd9:  return cy && !z;
      4'd10: return !cy || z;
      4'd11: return n == v;
      4'd12: return n != v;
      4'd13: return !z && (n == v);
      4'd14: return z || (n != v);
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] view_status();
`ifdef ALU_SINK_FORWARD_EN
    if (pend_acc) return (m_status & ~pend_m) | (pend_f & pend_m);
`endif
    return m_status;
  endfunction

  // Monitor: compares the presented outputs, retires popped entries.
  always @(negedge Clk) begin
    if (mon_en) begin
      logic [3:0] vs;
      vs = view_status();
      chk("InReady", 32'(alu_if.InReady),
          32'(!m_rst && exp_q.size() < 2));
      chk("OutValid", 32'(OutValid), 32'(exp_q.size() > 0));
      if (exp_q.size() > 0) begin
        chk("OutData", 32'(OutData), 32'(exp_q[0].d));
        chk("OutDest", 32'(OutDest), 32'(exp_q[0].t));
      end else if (m_rst) begin
        chk("OutData_rst", 32'(OutData), 32'(0));
        chk("OutDest_rst", 32'(OutDest), 32'(0));
      end
      chk("Status", 32'(Status), 32'(vs));
      chk("CondTrue", 32'(CondTrue), 32'(cond(vs, CondSel)));
      if (OutReady && exp_q.size() > 0 && !Reset)
        void'(exp_q.pop_front());
    end
  end

  task automatic step(input bit rst, input bit v, input logic [7:0] y,
                      input logic [3:0] f, input logic [3:0] m,
                      input logic [2:0] d, input bit ordy,
                      input logic [3:0] cs);
    @(posedge Clk);
    #1;
    if (pend_acc) begin
      exp_q.push_back(pend_ent);
      m_status = (m_status & ~pend_m) | (pend_f & pend_m);
    end
    if (Reset) begin
      exp_q.delete();
      m_status = 4'b0;
    end
    m_rst  = Reset;
    mon_en = 1'b1;
    Reset            = rst;
    alu_if.InValid   = v && !rst;
    alu_if.Y         = y;
    alu_if.OFlags    = f;
    alu_if.FlagMask  = m;
    alu_if.InDest    = d;
    OutReady         = ordy;
    CondSel          = cs;
    pend_acc = v && !rst && !m_rst && exp_q.size() < 2;
    pend_ent = '{d: y, t: d};
    pend_f   = f;
    pend_m   = m;
  endtask

  task automatic idle(input bit ordy, input logic [3:0] cs);
    step(1'b0, 1'b0, 8'h00, 4'h0, 4'h0, 3'd0, ordy, cs);
  endtask

  initial begin
    alu_if.InValid  = 1'b0;
    alu_if.Y        = '0;
    alu_if.OFlags   = '0;
    alu_if.FlagMask = '0;
    alu_if.InDest   = '0;
    // Reset for two edges, then release.
    step(1'b1, 1'b0, 8'h00, 4'h0, 4'h0, 3'd0, 1'b0, 4'd1);
    step(1'b0, 1'b0, 8'h00, 4'h0, 4'h0, 3'd0, 1'b0, 4'd1);
    @(negedge Clk);
    chk("rst_InReady_low", 32'(alu_if.InReady), 32'(0));
    idle(1'b1, 4'd1);
    @(negedge Clk);
    chk("post_rst_InReady", 32'(alu_if.InReady), 32'(1));

    step(1'b0, 1'b1, 8'h00, 4'b0001, 4'b1111, 3'd3, 1'b1, 4'd1);
    idle(1'b1, 4'd1);
    @(negedge Clk);
    chk("Z_commit", 32'(Status), 32'(4'b0001));
    chk("EQ_true", 32'(CondTrue), 32'(1));
    idle(1'b1, 4'd13);
    @(negedge Clk);
    chk("GT_false", 32'(CondTrue), 32'(0));

    step(1'b0, 1'b1, 8'h11, 4'h0, 4'h0, 3'd1, 1'b0, 4'd0);
    step(1'b0, 1'b1, 8'h22, 4'h0, 4'h0, 3'd2, 1'b0, 4'd0);
    step(1'b0, 1'b1, 8'h33, 4'hF, 4'hF, 3'd3, 1'b0, 4'd0);
    @(negedge Clk);
    chk("full_InReady", 32'(alu_if.InReady), 32'(0));
    idle(1'b0, 4'd0);
    idle(1'b1, 4'd0);
    idle(1'b1, 4'd0);
    idle(1'b1, 4'd0);

    step(1'b0, 1'b1, 8'h40, 4'b0010, 4'b1111, 3'd4, 1'b1, 4'd3);
    step(1'b0, 1'b1, 8'h41, 4'b1101, 4'b1100, 3'd5, 1'b1, 4'd11);
    idle(1'b1, 4'd11);
    @(negedge Clk);
    chk("mask_merge", 32'(Status), 32'(4'b1110));
    chk("GE_true", 32'(CondTrue), 32'(1));

    step(1'b0, 1'b1, 8'h5A, 4'h0, 4'h0, 3'd6, 1'b0, 4'd0);
    step(1'b0, 1'b1, 8'hA5, 4'h0, 4'h0, 3'd7, 1'b1, 4'd0);
    idle(1'b0, 4'd0);
    @(negedge Clk);
    chk("pushpop_head", 32'(OutData), 32'(8'hA5));
    idle(1'b1, 4'd0);
    idle(1'b1, 4'd0);

    step(1'b0, 1'b1, 8'h00, 4'b0000, 4'b1111, 3'd0, 1'b1, 4'd3);
    step(1'b0, 1'b1, 8'h01, 4'b0010, 4'b0010, 3'd1, 1'b1, 4'd3);
    @(negedge Clk);
`ifdef ALU_SINK_FORWARD_EN
    chk("fwd_carry_same", 32'(Status[1]), 32'(1));
`else
    chk("fwd_carry_same", 32'(Status[1]), 32'(0));
`endif
    idle(1'b1, 4'd3);
    @(negedge Clk);
    chk("carry_next", 32'(Status[1]), 32'(1));

    step(1'b0, 1'b1, 8'h77, 4'hF, 4'hF, 3'd2, 1'b0, 4'd0);
    step(1'b0, 1'b1, 8'h88, 4'hF, 4'hF, 3'd3, 1'b0, 4'd0);
    step(1'b1, 1'b0, 8'h00, 4'h0, 4'h0, 3'd0, 1'b0, 4'd0);
    step(1'b0, 1'b0, 8'h00, 4'h0, 4'h0, 3'd0, 1'b1, 4'd0);
    @(negedge Clk);
    chk("rst_full_OutValid", 32'(OutValid), 32'(0));
    chk("rst_full_Status", 32'(Status), 32'(0));
    idle(1'b1, 4'd0);

    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 59) == 0, $urandom_range(0, 2) != 0,
           8'($urandom), 4'($urandom), 4'($urandom), 3'($urandom),
           $urandom_range(0, 2) != 0, 4'($urandom));
    end
    idle(1'b1, 4'd0);
    idle(1'b1, 4'd0);
    idle(1'b1, 4'd0);
    @(negedge Clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
